// File: rtl/trig_taylor_seq.sv
// trig_taylor_seq: iterative Taylor-series cos(x) on unsigned fixed point; defining TRIG_SIN_EN adds sin(x) via mode=1.
module trig_taylor_seq #(
    parameter int W     = 10,
    parameter int FRAC  = 8,
    parameter int TERMS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] x,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = FRAC + 8;
    localparam int SW = 2 * W - FRAC;
    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, MULX = 3'd2, MULC = 3'd3, DONE = 3'd4;
    localparam logic signed [W+1:0] RMAX = (W+2)'(2 ** (W - 1) - 1);
    localparam logic signed [W+1:0] RMIN = ~RMAX;

    // Entry 0 is never addressed; it stays zero to avoid a divide by zero.
    function automatic logic [CW-1:0] coef(input int k, input bit s);
        longint d;
        if (k == 0) return '0;
        d = s ? longint'(2 * k * (2 * k + 1)) : longint'((2 * k - 1) * (2 * k));
        return CW'((longint'(1) << CW) / d);
    endfunction

    logic [2:0]        state;
    logic [W-1:0]      xr;
    logic [SW-1:0]     x2;
    logic [W:0]        t, p;
    logic signed [W+1:0] r;
    logic [2:0]        k;
    logic              s;
    logic [CW-1:0]     c;
    logic [CW-1:0]     cos_rom [8];
    logic [2*W-1:0]    xx;
    logic [W+SW:0]     tx;
    logic [W+CW:0]     pc;
    logic [W:0]        t0, p_next, t_next;
    logic signed [W+1:0] r_next;
    logic [W-1:0]      sat;

    for (genvar i = 0; i < 8; i++) begin : g_cos
        assign cos_rom[i] = coef(i, 1'b0);
    end

`ifdef TRIG_SIN_EN
    logic [CW-1:0] sin_rom [8];
    logic          sm;
    for (genvar i = 0; i < 8; i++) begin : g_sin
        assign sin_rom[i] = coef(i, 1'b1);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sm <= 1'b0;
        else if (state == IDLE && start) sm <= mode;
    end
    assign s = sm;
    assign c = s ? sin_rom[k] : cos_rom[k];
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign s = 1'b0;
    assign c = cos_rom[k];
`endif

    assign xx     = (2*W)'(xr) * (2*W)'(xr);
    assign tx     = (W+SW+1)'(t) * (W+SW+1)'(x2);
    assign pc     = (W+CW+1)'(p) * (W+CW+1)'(c);
    assign t0     = s ? (W+1)'(xr) : (W+1)'(2 ** FRAC);
    assign p_next = (W+1)'(tx >> FRAC);
    assign t_next = (W+1)'(pc >> CW);
    assign r_next = k[0] ? r - $signed((W+2)'(t_next)) : r + $signed((W+2)'(t_next));
    assign sat    = r_next > RMAX ? RMAX[W-1:0] : r_next < RMIN ? RMIN[W-1:0] : r_next[W-1:0];
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            xr     <= '0;
            x2     <= '0;
            t      <= '0;
            p      <= '0;
            r      <= '0;
            k      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xr    <= x;
                    state <= INIT;
                end
                INIT: begin
                    x2    <= SW'(xx >> FRAC);
                    t     <= t0;
                    r     <= $signed((W+2)'(t0));
                    k     <= 3'd1;
                    state <= MULX;
                end
                MULX: begin
                    p     <= p_next;
                    state <= MULC;
                end
                MULC: begin
                    t     <= t_next;
                    r     <= r_next;
                    k     <= k + 3'd1;
                    // The last term lands in result here so it is valid during DONE.
                    if (k == 3'(TERMS - 1)) begin
                        result <= sat;
                        state  <= DONE;
                    end else begin
                        state <= MULX;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trig_taylor_seq.sv
// tb_trig_taylor_seq: directed checks of trig_taylor_seq at default size and at W=16/FRAC=12/TERMS=2.
module tb_trig_taylor_seq;
`ifdef TRIG_SIN_EN
    localparam bit SIN = 1'b1;
`else
    localparam bit SIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, mode0, busy0, done0;
    logic [9:0]  x0, result0;
    logic        start1, mode1, busy1, done1;
    logic [15:0] x1, result1;
    logic        poke;
    int          checks, errors;

    always #5 clk = ~clk;

    trig_taylor_seq d0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .x(x0),
        .busy(busy0), .done(done0), .result(result0)
    );

    trig_taylor_seq #(.W(16), .FRAC(12), .TERMS(2)) d1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .x(x1),
        .busy(busy1), .done(done1), .result(result1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts clock edges from the start-sampling edge (1) to the edge after which done is seen.
    task automatic run0(input logic [9:0] xv, input logic m, input logic [9:0] exp, input string tag);
        int n;
        logic bz;
        @(negedge clk);
        start0 = 1'b1; x0 = xv; mode0 = m;
        @(posedge clk);
        #1 start0 = 1'b0; x0 = ~xv; mode0 = ~m;
        n = 1; bz = 1'b1;
        while (!done0 && n < 20) begin
            bz &= busy0;
            start0 = poke && n == 2;
            if (poke) x0 = 10'h000;
            @(posedge clk);
            #1 n++;
        end
        start0 = 1'b0;
        check({tag, "_lat"}, n, 8);
        check({tag, "_busy"}, {31'd0, bz & busy0}, 1);
        check({tag, "_res"}, {22'd0, result0}, {22'd0, exp});
        @(posedge clk);
        #1 check({tag, "_idle"}, {30'd0, busy0, done0}, 0);
    endtask

    task automatic run1(input logic [15:0] xv, input logic [15:0] exp, input string tag);
        int n;
        @(negedge clk);
        start1 = 1'b1; x1 = xv;
        @(posedge clk);
        #1 start1 = 1'b0; x1 = ~xv;
        n = 1;
        while (!done1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_res"}, {16'd0, result1}, {16'd0, exp});
        @(posedge clk);
        #1 check({tag, "_idle"}, {31'd0, busy1}, 0);
    endtask

    initial begin
        int n, first, second;
        checks = 0; errors = 0; poke = 1'b0;
        rst = 1'b1; start0 = 1'b0; mode0 = 1'b0; x0 = '0;
        start1 = 1'b0; mode1 = 1'b0; x1 = '0;
        repeat (2) @(posedge clk);
        #1 check("rst0", {21'd0, busy0, done0, result0}, 0);
        check("rst1", {15'd0, busy1, result1}, 0);
        @(negedge clk) rst = 1'b0;

        run0(10'h10C, 1'b0, 10'h080, "cos_pi3");
        run0(10'h000, 1'b0, 10'h100, "cos_0");
        run0(10'h000, 1'b1, SIN ? 10'h000 : 10'h100, "m1_0");
        run0(10'h086, 1'b1, SIN ? 10'h081 : 10'h0DD, "m1_pi6");
        run0(10'h086, 1'b0, 10'h0DD, "cos_pi6");
        run0(10'h3FF, 1'b0, 10'h200, "cos_sat");

        @(negedge clk);
        start0 = 1'b1; x0 = 10'h10C; mode0 = 1'b0;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("abort", {21'd0, busy0, done0, result0}, 0);
        @(negedge clk) rst = 1'b0;
        run0(10'h10C, 1'b0, 10'h080, "after_rst");

        poke = 1'b1;
        run0(10'h10C, 1'b0, 10'h080, "ign_start");
        poke = 1'b0;

        run1(16'h10C0, 16'h073C, "w16_pi3");
        run1(16'h2000, 16'hF000, "w16_2");
        run1(16'hFFFF, 16'h8000, "w16_sat");

        @(negedge clk);
        start0 = 1'b1; x0 = 10'h10C; mode0 = 1'b0;
        n = 0; first = 0; second = 0;
        repeat (30) begin
            @(posedge clk);
            #1 n++;
            if (done0) begin
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
        end
        start0 = 1'b0;
        check("b2b_first", first, 8);
        check("b2b_gap", second - first, 9);
        check("b2b_res", {22'd0, result0}, 32'h080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
